// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared definitions for the sprite blitter: FSM state encoding and the
//   default sprite / framebuffer geometry and transparent palette index.
package sprite_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int          SPR_W_D  = 32;
   localparam int          SPR_H_D  = 32;
   localparam int          FB_W_D   = 500;
   localparam int          FB_H_D   = 500;
   localparam logic [3:0]  TRANSP_D = 4'd0;

endpackage

// File: rtl/blit_raster_counter.sv
// blit_raster_counter
//   Walks the sprite in raster order (col fastest) and keeps the framebuffer
//   base address of the current screen row, advanced by one add per row.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_load           restart at (col 0, row 0) with row base for i_y
//   i_step           advance one pixel
//   i_y              sprite top screen row, used on i_load
//   o_col, o_row     current sprite column / row
//   o_row_base       (i_y + row) * FB_W
//   o_last           current pixel is the final one of the sprite
module blit_raster_counter
   import sprite_pkg::*;
#(
   parameter int SPR_W = SPR_W_D,
   parameter int SPR_H = SPR_H_D,
   parameter int FB_W  = FB_W_D,
   parameter int CW    = $clog2(SPR_W),
   parameter int RW    = $clog2(SPR_H)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_load,
   input  logic          i_step,
   input  logic [9:0]    i_y,
   output logic [CW-1:0] o_col,
   output logic [RW-1:0] o_row,
   output logic [19:0]   o_row_base,
   output logic          o_last
);

   localparam logic [CW-1:0] COL_MAX = CW'(SPR_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(SPR_H - 1);
   localparam logic [19:0]   FB_W_A  = 20'(FB_W);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [19:0]   r_base;
   logic [19:0]   w_base0;

   // Starting row base is a product by a constant, formed once per blit;
   // 20 bits so rows past the framebuffer cannot alias onto visible rows.
   assign w_base0 = 20'(int'(i_y) * FB_W);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_col  <= '0;
         r_row  <= '0;
         r_base <= '0;
      end else if (i_load) begin
         r_col  <= '0;
         r_row  <= '0;
         r_base <= w_base0;
      end else if (i_step) begin
         if (r_col == COL_MAX) begin
            r_col  <= '0;
            r_row  <= r_row + 1'b1;
            r_base <= r_base + FB_W_A;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_col      = r_col;
   assign o_row      = r_row;
   assign o_row_base = r_base;
   assign o_last     = (r_col == COL_MAX) && (r_row == ROW_MAX);

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter
//   Copies a SPR_W x SPR_H sprite from an external ROM into an external
//   framebuffer at (sprite_x, sprite_y), optionally mirrored, skipping the
//   transparent index and clipping pixels that fall off screen.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_start                 blit request, honoured only in IDLE
//   i_sprite_x/_y, i_mirror sprite placement / horizontal flip
//   o_busy, o_done          busy in RUN/DRAIN, done pulse on completion
//   o_rom_address, i_rom_q  sprite ROM port (1-cycle read latency)
//   o_fb_we, o_fb_address,
//   o_fb_data               framebuffer write port
module sprite_blitter
   import sprite_pkg::*;
#(
   parameter int         SPR_W  = SPR_W_D,
   parameter int         SPR_H  = SPR_H_D,
   parameter int         FB_W   = FB_W_D,
   parameter int         FB_H   = FB_H_D,
   parameter logic [3:0] TRANSP = TRANSP_D
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [9:0]  i_sprite_x,
   input  logic [9:0]  i_sprite_y,
   input  logic        i_mirror,
   output logic        o_busy,
   output logic        o_done,
   output logic [9:0]  o_rom_address,
   input  logic [3:0]  i_rom_q,
   output logic        o_fb_we,
   output logic [17:0] o_fb_address,
   output logic [3:0]  o_fb_data
);

   localparam int          CW      = $clog2(SPR_W);
   localparam int          RW      = $clog2(SPR_H);
   localparam logic [10:0] FB_W_X  = 11'(FB_W);
   localparam logic [10:0] FB_H_X  = 11'(FB_H);
   localparam logic [CW-1:0] COL_MAX = CW'(SPR_W - 1);

   state_t        r_state, w_next;
   logic [9:0]    r_x, r_y;
   logic          r_mirror;

   logic          w_accept, w_run, w_last, w_we;
   logic [CW-1:0] w_col, w_col_m;
   logic [RW-1:0] w_row;
   logic [19:0]   w_row_base;
   logic [10:0]   w_sx, w_sy;

   // Stage aligned with the ROM read: carries the pixel issued last cycle.
   logic          r_vld;
   logic [10:0]   r_sx, r_sy;
   logic [17:0]   r_addr;

   assign w_accept = (r_state == ST_IDLE) && i_start;
   assign w_run    = (r_state == ST_RUN);

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_start) w_next = ST_RUN;
         ST_RUN:   if (w_last)  w_next = ST_DRAIN;
         ST_DRAIN: w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_x      <= '0;
         r_y      <= '0;
         r_mirror <= 1'b0;
      end else if (w_accept) begin
         r_x      <= i_sprite_x;
         r_y      <= i_sprite_y;
         r_mirror <= i_mirror;
      end
   end

   blit_raster_counter #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H),
      .FB_W  (FB_W)
   ) u_cnt (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_accept),
      .i_step     (w_run),
      .i_y        (i_sprite_y),
      .o_col      (w_col),
      .o_row      (w_row),
      .o_row_base (w_row_base),
      .o_last     (w_last)
   );

   assign w_col_m       = r_mirror ? (COL_MAX - w_col) : w_col;
   assign o_rom_address = w_run ? 10'(int'(w_row) * SPR_W + int'(w_col_m)) : 10'd0;

   // Screen coordinates are 11 bits so x/y past 1023 still compare as off-screen.
   assign w_sx = 11'(r_x) + 11'(w_col);
   assign w_sy = 11'(r_y) + 11'(w_row);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_vld  <= 1'b0;
         r_sx   <= '0;
         r_sy   <= '0;
         r_addr <= '0;
      end else begin
         r_vld <= w_run;
         if (w_run) begin
            r_sx   <= w_sx;
            r_sy   <= w_sy;
            r_addr <= 18'(w_row_base + 20'(w_sx));
         end
      end
   end

   // Clipping on both axes: an x past the right edge is dropped instead of
   // spilling into the next framebuffer row.
   assign w_we = r_vld && (i_rom_q != TRANSP) && (r_sx < FB_W_X) && (r_sy < FB_H_X);

   assign o_fb_we      = w_we;
   assign o_fb_address = w_we ? r_addr  : 18'd0;
   assign o_fb_data    = w_we ? i_rom_q : 4'd0;

   assign o_busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign o_done = (r_state == ST_DONE);

endmodule
